instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch sequencer for the TB4004 core. Generates the 8-phase machine cycle (A1..X3), owns the 12-bit program counter that addresses the synchronous program ROM, and assembles the ROM's M1/M2 nibbles into OPR/OPA plus an optional second instruction byte. It sits between the ROM (`addr`/`cycle` out, `nibble` in) and the decoder/executor, which consumes the latched instruction and may redirect the PC.

## Interface

- `RESET_PC`, 12'h000, PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `nibble`  in  4  ROM data; OPR during cycle 3 (M1), OPA during cycle 4 (M2).
- `pc_load`  in  1  executor jump request, sampled only at cycle 7.
- `pc_target`  in  12  jump destination, sampled with `pc_load`.
- `hold`  in  1  stall request; port exists only with `FETCH_HOLD_EN`.
- `cycle`  out  3  current phase: 0=A1,1=A2,2=A3,3=M1,4=M2,5=X1,6=X2,7=X3.
- `addr`  out  12  ROM address (= PC), stable across an entire 8-phase cycle.
- `opr`  out  4  upper nibble of first instruction word.
- `opa`  out  4  lower nibble of first instruction word.
- `arg`  out  8  second instruction word (two-word instructions only).
- `word2`  out  1  high during the instruction cycle fetching a second word.
- `instr_valid`  out  1  high during cycles 5–7 of the cycle that completes an instruction.

## Operation

- Cycle counter: 0→7, wraps 7→0 every clock unless held.
- PC update at the edge leaving cycle 7: `pc_load`=1 → PC←`pc_target`; else PC←PC+1, 12'hFFF wraps to 12'h000. `pc_load` ignored in all other cycles.
- First-word cycle (`word2`=0): edge leaving cycle 3 latches `nibble`→`opr`; leaving cycle 4 latches `nibble`→`opa`.
- Two-word decode on the latched first word: OPR=1 (JCN), OPR=2 with OPA[0]=0 (FIM), OPR=4 (JUN), OPR=5 (JMS), OPR=7 (ISZ). All else single-word.
- Single-word: `instr_valid`=1 in cycles 5–7 of same cycle; `word2` stays 0.
- Two-word: `instr_valid`=0 in first cycle; `word2` goes 1 at edge leaving cycle 7 (same edge PC increments). In the `word2` cycle `opr`/`opa` hold; cycle-3/4 nibbles load `arg[7:4]`/`arg[3:0]`; `instr_valid`=1 in cycles 5–7; `word2` clears at edge leaving cycle 7.
- `pc_load` during a first-word cycle of a two-word instruction still redirects PC; `word2` sequencing unaffected (executor's responsibility not to do this).
- Reset: `cycle`=0, `addr`=`RESET_PC`, `opr`=`opa`=0, `arg`=0, `word2`=0, `instr_valid`=0. Reset at any phase aborts the in-flight fetch; no partial latch survives.

## Timing

- ROM registers `addr` one clock before use; `addr` changes only at 7→0, so ROM byte is valid by cycle 3 with ≥2 cycles slack.
- `opr` visible from cycle 4, `opa` from cycle 5; `instr_valid` registered, asserted at entry to cycle 5, deasserted at entry to cycle 0.
- New `addr` visible in cycle 0 following the cycle-7 edge.
- Throughput: one word per 8 clocks; single-word instruction 8 clocks, two-word 16.

## Configuration

- `FETCH_HOLD_EN` defined: `hold` port present. When `hold`=1 at an edge where `cycle`=0, counter stays 0, PC and all latches unchanged. `hold` has no effect in cycles 1–7 (an instruction cycle always completes).
- Undefined: no `hold` port; counter free-runs.

## Test plan

- Reset then ROM[0]=0xD5: cycle 3/4 give D/5 → `opr`=4'hD, `opa`=4'h5, `instr_valid`=1 for cycles 5–7, `addr` 0→1 at next cycle 0.
- ROM[0..1]=0x40,0x23 (JUN): first cycle `instr_valid`=0, `word2`=1 in second cycle, `arg`=8'h23, `opr`=4/`opa`=0 held; `pc_load`=1, `pc_target`=12'h023 at cycle 7 → `addr`=12'h023.
- ROM[0]=0x20 (FIM) vs ROM[0]=0x21 (SRC): 0x20 asserts `word2`; 0x21 gives `instr_valid` in first cycle, `word2`=0.
- PC at 12'hFFF, no load → `addr`=12'h000 after cycle 7.
- `rst` asserted during cycle 4 of a JUN first word → next cycle `cycle`=0, `addr`=`RESET_PC`, `word2`=0, `opr`=`opa`=0.
- With `FETCH_HOLD_EN`, `hold`=1 for 5 clocks from cycle 0 → `cycle` stays 0, `addr` unchanged; asserted at cycle 2 → no stall until next cycle 0.

Source files
------------

// File: rtl/instr_fetch.sv
// TB4004 instruction-fetch sequencer: 8-phase machine cycle, 12-bit PC, OPR/OPA/ARG assembly.
// Optional stall input enabled by defining FETCH_HOLD_EN.
module instr_fetch #(
   parameter logic [11:0] RESET_PC = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  nibble,
   input  logic        pc_load,
   input  logic [11:0] pc_target,
`ifdef FETCH_HOLD_EN
   input  logic        hold,
`endif
   output logic [2:0]  cycle,
   output logic [11:0] addr,
   output logic [3:0]  opr,
   output logic [3:0]  opa,
   output logic [7:0]  arg,
   output logic        word2,
   output logic        instr_valid
);

   typedef enum logic [2:0] {
      A1 = 3'd0, A2 = 3'd1, A3 = 3'd2, M1 = 3'd3,
      M2 = 3'd4, X1 = 3'd5, X2 = 3'd6, X3 = 3'd7
   } phase_t;

   phase_t      phase, phase_nxt;
   logic        stall;
   logic [11:0] pc;

   // JCN, FIM (even OPA), JUN, JMS and ISZ carry a second instruction word.
   function automatic logic is_two_word(input logic [3:0] op, input logic a0);
      return (op == 4'h1) || (op == 4'h4) || (op == 4'h5) || (op == 4'h7) ||
             ((op == 4'h2) && !a0);
   endfunction

`ifdef FETCH_HOLD_EN
   assign stall = hold && (phase == A1);
`else
   assign stall = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) phase <= A1;
      else     phase <= phase_nxt;
   end

   always_comb begin
      phase_nxt = phase;
      if (!stall) begin
         case (phase)
            A1:      phase_nxt = A2;
            A2:      phase_nxt = A3;
            A3:      phase_nxt = M1;
            M1:      phase_nxt = M2;
            M2:      phase_nxt = X1;
            X1:      phase_nxt = X2;
            X2:      phase_nxt = X3;
            default: phase_nxt = A1;
         endcase
      end
   end

   // Stalls only ever occur in A1, where no datapath register changes anyway.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         opr         <= '0;
         opa         <= '0;
         arg         <= '0;
         word2       <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         case (phase)
            M1: begin
               if (word2) arg[7:4] <= nibble;
               else       opr      <= nibble;
            end
            M2: begin
               if (word2) begin
                  arg[3:0]    <= nibble;
                  instr_valid <= 1'b1;
               end else begin
                  opa         <= nibble;
                  instr_valid <= !is_two_word(opr, nibble[0]);
               end
            end
            X3: begin
               instr_valid <= 1'b0;
               word2       <= !word2 && is_two_word(opr, opa[0]);
               pc          <= pc_load ? pc_target : pc + 12'd1;
            end
            default: ;
         endcase
      end
   end

   assign cycle = phase;
   assign addr  = pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-cycle reference model plus directed literal checks.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  nibble = 4'h0;
   logic        pc_load = 1'b0;
   logic [11:0] pc_target = 12'h000;
   logic        hold = 1'b0;
   logic [2:0]  cycle;
   logic [11:0] addr;
   logic [3:0]  opr, opa;
   logic [7:0]  arg;
   logic        word2, instr_valid;

   int errs = 0;
   int checks = 0;

   logic [7:0] rom [0:4095];

   instr_fetch #(.RESET_PC(12'h000)) dut (
      .clk(clk), .rst(rst), .nibble(nibble), .pc_load(pc_load), .pc_target(pc_target),
`ifdef FETCH_HOLD_EN
      .hold(hold),
`endif
      .cycle(cycle), .addr(addr), .opr(opr), .opa(opa), .arg(arg),
      .word2(word2), .instr_valid(instr_valid)
   );

   always #5 clk = ~clk;

   // ROM: presents the high nibble in M1 and the low nibble in M2 of the addressed byte.
   always @(negedge clk) begin
      logic [7:0] b;
      b = rom[addr];
      if (cycle == 3'd3)      nibble = b[7:4];
      else if (cycle == 3'd4) nibble = b[3:0];
      else                    nibble = 4'h0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic needs_second(input logic [7:0] b);
      int op;
      op = int'(b[7:4]);
      return (op == 1) || (op == 4) || (op == 5) || (op == 7) || (op == 2 && b[0] == 1'b0);
   endfunction

   // Reference model, advanced once per rising edge from the same inputs the DUT sees.
   int         m_cyc = 0, m_pc = 0;
   logic [3:0] m_opr = '0, m_opa = '0;
   logic [7:0] m_arg = '0;
   logic       m_w2 = 1'b0, m_valid = 1'b0, m_init = 1'b0;

   always @(posedge clk) begin
      logic [7:0] b;
      b = rom[m_pc];
      if (rst) begin
         m_cyc = 0; m_pc = 0; m_opr = '0; m_opa = '0; m_arg = '0;
         m_w2 = 1'b0; m_valid = 1'b0; m_init = 1'b1;
      end else if (m_init && !(hold && m_cyc == 0)) begin
         if (m_cyc == 3) begin
            if (m_w2) m_arg = {b[7:4], m_arg[3:0]};
            else      m_opr = b[7:4];
         end else if (m_cyc == 4) begin
            if (m_w2) begin
               m_arg = {m_arg[7:4], b[3:0]};
               m_valid = 1'b1;
            end else begin
               m_opa = b[3:0];
               m_valid = !needs_second({m_opr, m_opa});
            end
         end else if (m_cyc == 7) begin
            m_valid = 1'b0;
            m_w2 = !m_w2 && needs_second({m_opr, m_opa});
            m_pc = pc_load ? int'(pc_target) : (m_pc + 1) % 4096;
         end
         m_cyc = (m_cyc + 1) % 8;
      end
   end

   always @(posedge clk) begin
      #1;
      if (m_init) begin
         chk("m_cycle", {29'b0, cycle}, m_cyc);
         chk("m_addr",  {20'b0, addr},  m_pc);
         chk("m_opr",   {28'b0, opr},   {28'b0, m_opr});
         chk("m_opa",   {28'b0, opa},   {28'b0, m_opa});
         chk("m_arg",   {24'b0, arg},   {24'b0, m_arg});
         chk("m_word2", {31'b0, word2}, {31'b0, m_w2});
         chk("m_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the bench at a falling edge inside cycle 0 with rst released.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
   endtask

   initial begin
      clear_rom();

      // Single-word 0xD5
      rom[0] = 8'hD5;
      do_reset();
      chk("rst_cycle", {29'b0, cycle}, 0);
      chk("rst_addr",  {20'b0, addr}, 0);
      chk("rst_opr",   {28'b0, opr}, 0);
      chk("rst_valid", {31'b0, instr_valid}, 0);
      tick(5);
      chk("d5_opr",   {28'b0, opr}, 32'hD);
      chk("d5_opa",   {28'b0, opa}, 32'h5);
      chk("d5_valid", {31'b0, instr_valid}, 1);
      tick(3);
      chk("d5_addr_next",  {20'b0, addr}, 1);
      chk("d5_valid_off",  {31'b0, instr_valid}, 0);
      chk("d5_word2",      {31'b0, word2}, 0);

      // JUN 0x40 0x23 with executor redirect
      clear_rom();
      rom[0] = 8'h40; rom[1] = 8'h23;
      do_reset();
      tick(5);
      chk("jun_valid1", {31'b0, instr_valid}, 0);
      tick(3);
      chk("jun_word2", {31'b0, word2}, 1);
      chk("jun_addr1", {20'b0, addr}, 1);
      tick(5);
      chk("jun_arg",    {24'b0, arg}, 32'h23);
      chk("jun_opr",    {28'b0, opr}, 4);
      chk("jun_opa",    {28'b0, opa}, 0);
      chk("jun_valid2", {31'b0, instr_valid}, 1);
      tick(2);
      pc_load = 1'b1; pc_target = 12'h023;
      tick(1);
      pc_load = 1'b0; pc_target = 12'h000;
      chk("jun_target", {20'b0, addr}, 32'h023);
      chk("jun_w2_clr", {31'b0, word2}, 0);
      tick(8);

      // pc_load outside cycle 7 is ignored
      pc_load = 1'b1; pc_target = 12'h555;
      tick(4);
      pc_load = 1'b0;
      tick(4);
      chk("load_ignored", {20'b0, addr}, 32'h025);

      // FIM vs SRC
      clear_rom();
      rom[0] = 8'h20;
      do_reset();
      tick(8);
      chk("fim_word2", {31'b0, word2}, 1);
      rom[0] = 8'h21;
      do_reset();
      tick(5);
      chk("src_valid", {31'b0, instr_valid}, 1);
      tick(3);
      chk("src_word2", {31'b0, word2}, 0);

      // PC wrap FFF -> 000
      clear_rom();
      do_reset();
      tick(7);
      pc_load = 1'b1; pc_target = 12'hFFF;
      tick(1);
      pc_load = 1'b0; pc_target = 12'h000;
      chk("wrap_fff", {20'b0, addr}, 32'hFFF);
      tick(8);
      chk("wrap_000", {20'b0, addr}, 0);

      // Reset during cycle 4 of JUN first word
      rom[0] = 8'h40; rom[1] = 8'h23;
      do_reset();
      tick(4);
      chk("abort_opr_pre", {28'b0, opr}, 4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("abort_cycle", {29'b0, cycle}, 0);
      chk("abort_addr",  {20'b0, addr}, 0);
      chk("abort_word2", {31'b0, word2}, 0);
      chk("abort_opr",   {28'b0, opr}, 0);
      chk("abort_opa",   {28'b0, opa}, 0);
      tick(8);
      chk("abort_rerun_w2", {31'b0, word2}, 1);

      // Mixed stream covering JCN, ISZ, JMS, FIM/SRC and single-word ops
      clear_rom();
      rom[0] = 8'h71; rom[1] = 8'h05; rom[2] = 8'h22; rom[3] = 8'h33;
      rom[4] = 8'hA3; rom[5] = 8'h10; rom[6] = 8'h44; rom[7] = 8'h52;
      rom[8] = 8'h9C; rom[9] = 8'h23; rom[10] = 8'hF0; rom[11] = 8'h3E;
      do_reset();
      tick(96);
      chk("stream_addr", {20'b0, addr}, 12);

`ifdef FETCH_HOLD_EN
      clear_rom();
      do_reset();
      hold = 1'b1;
      tick(5);
      chk("hold_cycle", {29'b0, cycle}, 0);
      chk("hold_addr",  {20'b0, addr}, 0);
      hold = 1'b0;
      tick(2);
      hold = 1'b1;
      tick(6);
      chk("hold_late_cycle", {29'b0, cycle}, 0);
      chk("hold_late_addr",  {20'b0, addr}, 1);
      tick(1);
      chk("hold_stall", {29'b0, cycle}, 0);
      hold = 1'b0;
      tick(1);
      chk("hold_release", {29'b0, cycle}, 1);
`endif

      tick(2);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
